// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// It grants one word per frame and follows the transmitter's ready flag through that frame.
module uart_tx_arbiter #(
    parameter int WORD_LENGTH = 8,
    parameter int NUM_REQ     = 4,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] data_in,
    output logic [NUM_REQ-1:0]             ack,
    input  logic                           tx_ready,
    output logic                           tx_send,
    output logic [WORD_LENGTH-1:0]         tx_data,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy,
    output logic                           err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                 r_state;
    logic [ID_W-1:0]        r_last;
    logic [NUM_REQ-1:0]     r_ack;
    logic                   r_tx_send;
    logic [WORD_LENGTH-1:0] r_tx_data;
    logic [ID_W-1:0]        r_grant_id;
    logic                   r_busy;
    logic                   r_err;

    logic [WORD_LENGTH-1:0] w_words [NUM_REQ];
    logic [ID_W-1:0]        w_win;
    logic [ID_W-1:0]        w_idx;
    logic                   w_found;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_words[gi] = data_in[gi*WORD_LENGTH +: WORD_LENGTH];
    end

    // Scan from the farthest offset down to last+1 so the nearest set bit after last wins.
    always_comb begin
        w_win   = r_last;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
            if (req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last     <= ID_W'(NUM_REQ - 1);
            r_ack      <= '0;
            r_tx_send  <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_tx_send <= 1'b0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_ready && w_found) begin
                        r_tx_data  <= w_words[w_win];
                        r_grant_id <= w_win;
                        r_last     <= w_win;
                        r_ack      <= NUM_REQ'(1) << w_win;
                        r_tx_send  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        // Transmitter never took the word; it is dropped, not retried.
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign tx_send  = r_tx_send;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule
